// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding, stall/flush generation,
// a scoreboard for one multi-cycle MUL/DIV unit and a saturating stall counter.
module hazard_unit_sb #(
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 4,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic [REG_AW-1:0] wreg_d,
  input  logic              regwrite_d,
  input  logic              branch_d,
  input  logic              mul_start_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwrite_w,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              fwd_a_d,
  output logic              fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [REG_AW-1:0] mul_wreg,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam bit FWD = (FWD_EN != 0);

  typedef logic [REG_AW-1:0] reg_t;

  function automatic logic src_hit(input reg_t x, input reg_t rs, input reg_t rt,
                                   input logic urs, input logic urt);
    return (x != '0) && ((urs && (rs == x)) || (urt && (rt == x)));
  endfunction

  // MEM result has priority over WB result for the EX operand select
  function automatic logic [1:0] ex_sel(input reg_t src, input reg_t wm, input reg_t ww,
                                        input logic rwm, input logic rww);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rwm && (src == wm))      sel = 2'b10;
      else if (rww && (src == ww)) sel = 2'b01;
    end
    return sel;
  endfunction

  logic [CW-1:0]    cnt_q, cnt_d;
  reg_t             dst_q, dst_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             lw_stall, br_stall, mul_stall, raw_stall, stall, issue;

  assign mul_busy  = (cnt_q != '0);
  assign mul_done  = (cnt_q == CW'(1));
  assign mul_wreg  = dst_q;
  assign stall_cnt = scnt_q;

  always_comb begin
    lw_stall  = memtoreg_e && src_hit(wreg_e, rs_d, rt_d, use_rs_d, use_rt_d);
    br_stall  = branch_d &&
                ((regwrite_e && src_hit(wreg_e, rs_d, rt_d, use_rs_d, use_rt_d)) ||
                 (memtoreg_m && src_hit(wreg_m, rs_d, rt_d, use_rs_d, use_rt_d)));
    mul_stall = mul_busy &&
                (src_hit(dst_q, rs_d, rt_d, use_rs_d, use_rt_d) ||
                 (regwrite_d && (wreg_d != '0) && (wreg_d == dst_q)) ||
                 mul_start_d);
    raw_stall = 1'b0;
    if (!FWD) begin
      // WB needs no stall: the register file writes in the first half-cycle
      raw_stall = (regwrite_e && src_hit(wreg_e, rs_d, rt_d, use_rs_d, use_rt_d)) ||
                  (regwrite_m && src_hit(wreg_m, rs_d, rt_d, use_rs_d, use_rt_d));
    end
    stall = rst_n && valid_d && (lw_stall || br_stall || mul_stall || raw_stall);
    issue = mul_start_d && valid_d && !stall;

    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    fwd_a_d = 1'b0;
    fwd_b_d = 1'b0;
    if (FWD && rst_n) begin
      fwd_a_e = ex_sel(rs_e, wreg_m, wreg_w, regwrite_m, regwrite_w);
      fwd_b_e = ex_sel(rt_e, wreg_m, wreg_w, regwrite_m, regwrite_w);
      fwd_a_d = regwrite_m && (rs_d != '0) && (rs_d == wreg_m);
      fwd_b_d = regwrite_m && (rt_d != '0) && (rt_d == wreg_m);
    end
  end

  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;

  always_comb begin
    cnt_d  = cnt_q;
    dst_d  = dst_q;
    scnt_d = scnt_q;
    if (issue) begin
      cnt_d = CW'(MUL_LAT);
      dst_d = wreg_d;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (stall && (scnt_q != '1)) scnt_d = scnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dst_q  <= '0;
      scnt_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dst_q  <= dst_d;
      scnt_q <= scnt_d;
    end
  end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Parametrised successor to the pipeline hazard unit for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It produces the stall, flush and forward-select signals from the register fields of the ID, EX, MEM and WB stages. It adds three things: a scoreboard for one multi-cycle execution unit (MUL/DIV) with a configurable latency, a compile-time no-forwarding mode, and a saturating stall performance counter.

## Interface
Parameters:
- REG_AW, 5, register address width
- MUL_LAT, 4, multi-cycle unit latency in cycles; must be ≥2
- FWD_EN, 1, 1 = forwarding enabled; 0 = resolve every RAW hazard by stalling
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_d  in  1  ID holds a real instruction
- rs_d, rt_d  in  REG_AW  ID source registers
- use_rs_d, use_rt_d  in  1  ID actually reads rs/rt
- wreg_d  in  REG_AW  ID destination register
- regwrite_d  in  1  ID instruction writes a register
- branch_d  in  1  ID is a branch, resolved in ID
- mul_start_d  in  1  ID issues to the multi-cycle unit; its destination is wreg_d
- rs_e, rt_e, wreg_e  in  REG_AW  EX fields
- regwrite_e, memtoreg_e  in  1  EX controls
- wreg_m  in  REG_AW  MEM destination
- regwrite_m, memtoreg_m  in  1  MEM controls
- wreg_w  in  REG_AW  WB destination
- regwrite_w  in  1  WB control
- stall_f, stall_d  out  1  hold PC and the IF/ID register
- flush_e  out  1  clear the ID/EX register (insert bubble)
- fwd_a_d, fwd_b_d  out  1  ID comparator operand takes ALUOutM
- fwd_a_e, fwd_b_e  out  2  EX operand select: 00 register file, 01 ResultW, 10 ALUOutM
- mul_busy  out  1  multi-cycle unit occupied
- mul_done  out  1  one-cycle pulse; the unit writes mul_wreg this cycle
- mul_wreg  out  REG_AW  destination of the in-flight multi-cycle op
- stall_cnt  out  CNT_W  saturating count of stall_d cycles

## Operation
- Register 0 never creates a hazard: every match below also requires the register to be non-zero.
- "src hit X" means: (use_rs_d && rs_d==X) || (use_rt_d && rt_d==X).

Forwarding (FWD_EN=1):
- fwd_a_e = 10 if regwrite_m && rs_e==wreg_m.
- Otherwise fwd_a_e = 01 if regwrite_w && rs_e==wreg_w.
- Otherwise fwd_a_e = 00. fwd_b_e follows the same rule using rt_e.
- fwd_a_d = regwrite_m && rs_d==wreg_m. fwd_b_d uses rt_d.

Stall causes (each is gated by valid_d):
- lw_stall = memtoreg_e && src hit wreg_e.
- br_stall = branch_d && ((regwrite_e && src hit wreg_e) || (memtoreg_m && src hit wreg_m)).
- mul_stall = mul_busy && (src hit mul_wreg || (regwrite_d && wreg_d==mul_wreg) || mul_start_d). This covers RAW and WAW hazards and a structural busy unit.
- With FWD_EN=0, all forward outputs are 0, and:
  - raw_stall = (regwrite_e && src hit wreg_e) || (regwrite_m && src hit wreg_m).
  - The WB stage is not a hazard, because the register file writes in the first half-cycle.
- stall = lw_stall | br_stall | mul_stall | raw_stall.
- stall_f = stall_d = flush_e = stall. All three are combinational.

Multi-cycle scoreboard:
- State is a counter cnt of width clog2(MUL_LAT+1), plus dst_q.
- An issue is accepted when mul_start_d && valid_d && !stall. On an accepted issue: cnt <= MUL_LAT, dst_q <= wreg_d.
- Otherwise, if cnt != 0, cnt decrements by 1 each cycle.
- mul_busy = (cnt != 0). mul_done = (cnt == 1). mul_wreg = dst_q.
- A new issue is never accepted while busy, including the cnt==1 cycle.

Stall counter:
- stall_cnt increments on every clock edge at which stall is 1.
- It saturates at 2^CNT_W−1 and does not wrap.

## Timing
- All forward, stall and flush outputs are combinational from the current inputs and the registered state, with zero latency.
- Reset (rst_n low, asynchronous): cnt=0, dst_q=0, stall_cnt=0. Therefore mul_busy=0, mul_done=0 and mul_wreg=0.
- While rst_n is low, stall_f, stall_d, flush_e and all forward selects are also forced to 0.
- A reset asserted mid-operation abandons the in-flight multi-cycle op; no mul_done pulse is issued for it.
- An issue accepted at edge N gives mul_busy high for cycles N+1 … N+MUL_LAT, with mul_done high in cycle N+MUL_LAT.
- A dependent instruction waiting in ID is released in the cycle after mul_done.
- When a load-use hazard and a mul hazard occur together, a single stall is output. stall_cnt counts one per cycle regardless of how many causes are active.

## Test plan
- EX forwarding priority: wreg_m=wreg_w=3, regwrite_m=regwrite_w=1, rs_e=3 → fwd_a_e=10. Drop regwrite_m → fwd_a_e=01. Set rs_e=0 → fwd_a_e=00.
- Load-use: memtoreg_e=1, wreg_e=5, use_rs_d=1, rs_d=5 → stall_f=stall_d=flush_e=1. Next cycle with memtoreg_e=0 → stall=0 and stall_cnt=1.
- Branch hazard: branch_d=1, regwrite_e=1, wreg_e=7, rt_d=7, use_rt_d=1 → stall=1. Move the writer to MEM as an ALU op → stall=0, fwd_b_d=1.
- Multi-cycle, MUL_LAT=4: issue with wreg_d=9 at edge 0 → mul_busy for cycles 1–4, mul_done only in cycle 4. An ID reader of r9 stalls in cycles 1–4. A second mul_start_d stalls until cycle 5.
- FWD_EN=0: regwrite_m=1, wreg_m=2, rs_d=2 → stall=1 and all fwd outputs 0.
- Reset mid-mul at cycle 2 → mul_busy=0 and stall_cnt=0 immediately; no mul_done pulse follows. Separately, force stall for 2^CNT_W+3 cycles → stall_cnt holds at all-ones.
